// File: rtl/div_pkg.sv
// Shared constants for the divider front end: FSM state codes, default widths
// and the order in which operand bytes arrive on the bus.
package div_pkg;

  localparam int unsigned OP_W_DEFAULT   = 16;
  localparam int unsigned BYTE_W_DEFAULT = 8;
  localparam int unsigned NB_DEFAULT     = OP_W_DEFAULT / BYTE_W_DEFAULT;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

  localparam int unsigned SLOT_DVD_HI = 0;
  localparam int unsigned SLOT_DVD_LO = NB_DEFAULT - 1;
  localparam int unsigned SLOT_DVS_HI = NB_DEFAULT;
  localparam int unsigned SLOT_DVS_LO = 2 * NB_DEFAULT - 1;

endpackage

// File: rtl/input_wrapper_if.sv
// Byte-bus and divider-side signals of input_wrapper; slave is the wrapper's view.
interface input_wrapper_if
  import div_pkg::*;
#(
  parameter int unsigned OP_W   = OP_W_DEFAULT,
  parameter int unsigned BYTE_W = BYTE_W_DEFAULT
);
  logic [BYTE_W-1:0] bus_in;
  logic              bus_valid;
  logic              bus_ready;
  logic              div_ready;
  logic              div_done;
  logic              start;
  logic [OP_W-1:0]   dividend_16b;
  logic [OP_W-1:0]   divisor_16b;
  logic              dz_err;
  logic              busy;

  modport slave (
    input  bus_in, bus_valid, div_ready, div_done,
    output bus_ready, start, dividend_16b, divisor_16b, dz_err, busy
  );

  modport master (
    output bus_in, bus_valid, div_ready, div_done,
    input  bus_ready, start, dividend_16b, divisor_16b, dz_err, busy
  );
endinterface

// File: rtl/input_wrapper_cu.sv
// Control FSM of input_wrapper: sequences byte collection, the zero-divisor
// check, the divider launch and the wait for its completion.
module input_wrapper_cu
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bus_valid,
  input  logic div_ready,
  input  logic div_done,
  input  logic last_slot,
  input  logic dvs_zero,
  output logic bus_ready,
  output logic start,
  output logic dz_err,
  output logic busy,
  output logic cnt_clr,
  output logic cnt_inc,
  output logic load
);

  logic [1:0] state, state_nxt;
  logic       xfer;
  logic       dz_pend;

  assign xfer = bus_valid & bus_ready;
  assign busy = (state != S_COLLECT);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load      = 1'b0;
    case (state)
      S_COLLECT: begin
        if (xfer) begin
          load    = 1'b1;
          cnt_inc = 1'b1;
          if (last_slot) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dvs_zero) begin
          cnt_clr   = 1'b1;
          state_nxt = S_COLLECT;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (div_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // start is high only in the first WAIT cycle; a done there is stale
        if (div_done && !start) begin
          cnt_clr   = 1'b1;
          state_nxt = S_COLLECT;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  // bus_ready and dz_err follow the state one cycle late, so both rise two
  // edges after the last byte of a zero-divisor set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_COLLECT;
      bus_ready <= 1'b0;
      start     <= 1'b0;
      dz_pend   <= 1'b0;
      dz_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_ready <= (state == S_COLLECT) && !(xfer && last_slot);
      start     <= (state == S_ISSUE) && div_ready;
      dz_pend   <= (state == S_CHECK) && dvs_zero;
      dz_err    <= dz_pend;
    end
  end

endmodule

// File: rtl/input_wrapper_dp.sv
// Datapath of input_wrapper: slot counter, slot decoder and the two operand
// registers, filled MSB byte first (dividend slots, then divisor slots).
module input_wrapper_dp
  import div_pkg::*;
#(
  parameter int unsigned OP_W   = OP_W_DEFAULT,
  parameter int unsigned BYTE_W = BYTE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] bus_in,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  input  logic              load,
  output logic              last_slot,
  output logic              dvs_zero,
  output logic [OP_W-1:0]   dividend,
  output logic [OP_W-1:0]   divisor
);

  localparam int unsigned NB = OP_W / BYTE_W;
  localparam int unsigned CW = (2 * NB > 1) ? $clog2(2 * NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * NB - 1);

  logic [CW-1:0] cnt;

  assign last_slot = (cnt == LAST);
  assign dvs_zero  = (divisor == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= last_slot ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend <= '0;
      divisor  <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (cnt == CW'(NB - 1 - i))     dividend[i*BYTE_W +: BYTE_W] <= bus_in;
        if (cnt == CW'(2 * NB - 1 - i)) divisor[i*BYTE_W +: BYTE_W]  <= bus_in;
      end
    end
  end

endmodule

// File: rtl/input_wrapper.sv
// Divider front end: assembles dividend and divisor from a byte stream and
// launches the divider once per operand set.
module input_wrapper
  import div_pkg::*;
#(
  parameter int unsigned OP_W   = OP_W_DEFAULT,
  parameter int unsigned BYTE_W = BYTE_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input_wrapper_if.slave  io
);

  logic cnt_clr, cnt_inc, load;
  logic last_slot, dvs_zero;

  input_wrapper_cu u_cu (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (io.bus_valid),
    .div_ready (io.div_ready),
    .div_done  (io.div_done),
    .last_slot (last_slot),
    .dvs_zero  (dvs_zero),
    .bus_ready (io.bus_ready),
    .start     (io.start),
    .dz_err    (io.dz_err),
    .busy      (io.busy),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc),
    .load      (load)
  );

  input_wrapper_dp #(
    .OP_W   (OP_W),
    .BYTE_W (BYTE_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (io.bus_in),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc),
    .load      (load),
    .last_slot (last_slot),
    .dvs_zero  (dvs_zero),
    .dividend  (io.dividend_16b),
    .divisor   (io.divisor_16b)
  );

endmodule

// File: tb/tb_input_wrapper.sv
// Bench for input_wrapper: directed scenarios plus randomized operand streams,
// compared every cycle against a transaction-level model of the wrapper.
module tb_input_wrapper;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rnd_on = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  input_wrapper_if #(.OP_W(16), .BYTE_W(8)) io ();

  input_wrapper #(.OP_W(16), .BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A set is "full" from its last accepted byte until it is either rejected
  // (zero divisor) or the divider reports done after the launch.
  bit          m_full = 1'b0, m_checked = 1'b0, m_launched = 1'b0, m_dz_pend = 1'b0;
  int unsigned m_slot = 0;
  logic        m_ready = 1'b0, m_start = 1'b0, m_dz = 1'b0;
  logic [15:0] m_dvd = '0, m_dvs = '0;

  task automatic model_step();
    bit was_collect, prev_start;
    if (rst) begin
      m_full = 0; m_checked = 0; m_launched = 0; m_dz_pend = 0; m_slot = 0;
      m_ready = 0; m_start = 0; m_dz = 0; m_dvd = '0; m_dvs = '0;
      return;
    end
    was_collect = !m_full;
    prev_start  = m_start;
    m_start     = 1'b0;
    m_dz        = m_dz_pend;
    m_dz_pend   = 1'b0;
    if (!m_full) begin
      if (io.bus_valid && m_ready) begin
        if (m_slot == SLOT_DVD_HI)      m_dvd[15:8] = io.bus_in;
        else if (m_slot == SLOT_DVD_LO) m_dvd[7:0]  = io.bus_in;
        else if (m_slot == SLOT_DVS_HI) m_dvs[15:8] = io.bus_in;
        else                            m_dvs[7:0]  = io.bus_in;
        if (m_slot == SLOT_DVS_LO) begin
          m_slot = 0; m_full = 1; m_checked = 0;
        end else begin
          m_slot++;
        end
      end
    end else if (!m_checked) begin
      m_checked = 1;
      if (m_dvs == 16'h0000) begin
        m_dz_pend = 1; m_full = 0;
      end
    end else if (!m_launched) begin
      if (io.div_ready) begin
        m_start = 1; m_launched = 1;
      end
    end else if (io.div_done && !prev_start) begin
      m_full = 0; m_launched = 0;
    end
    m_ready = was_collect && !m_full;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for bus_ready at %0t", name, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check1 ("bus_ready", io.bus_ready,    m_ready);
      check1 ("start",     io.start,        m_start);
      check1 ("dz_err",    io.dz_err,       m_dz);
      check1 ("busy",      io.busy,         m_full);
      check16("dividend",  io.dividend_16b, m_dvd);
      check16("divisor",   io.divisor_16b,  m_dvs);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rnd_on) begin
      io.div_ready = ($urandom_range(0, 3) != 0);
      io.div_done  = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check1 ("rst_bus_ready", io.bus_ready,    1'b0);
    check1 ("rst_start",     io.start,        1'b0);
    check1 ("rst_dz_err",    io.dz_err,       1'b0);
    check1 ("rst_busy",      io.busy,         1'b0);
    check16("rst_dividend",  io.dividend_16b, 16'h0000);
    check16("rst_divisor",   io.divisor_16b,  16'h0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    io.bus_in    = b;
    io.bus_valid = 1'b1;
    while (io.bus_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout_fail("send_byte");
    tick();
    io.bus_valid = 1'b0;
  endtask

  task automatic pulse_done();
    io.div_done = 1'b1;
    tick();
    io.div_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [7:0] sb [4];
    io.bus_in = '0; io.bus_valid = 1'b0; io.div_ready = 1'b0; io.div_done = 1'b0;

    do_reset();
    tick();
    check1("ready_after_rst", io.bus_ready, 1'b1);

    // reset mid-collect, then a fresh set
    io.div_ready = 1'b1;
    send_byte(8'h12); send_byte(8'h34);
    do_reset();
    tick();
    send_byte(8'h00); send_byte(8'h64); send_byte(8'h00); send_byte(8'h07);
    check1("t1_start_n1", io.start, 1'b0);
    tick();
    check1("t1_start_n2", io.start, 1'b0);
    tick();
    check1 ("t1_start", io.start, 1'b1);
    check16("t1_dvd", io.dividend_16b, 16'h0064);
    check16("t1_dvs", io.divisor_16b,  16'h0007);
    io.div_done = 1'b1;             // coincides with start: must be ignored
    tick();
    io.div_done = 1'b0;
    check1("t1_busy_after_stale_done", io.busy, 1'b1);
    tick(); tick();
    pulse_done();
    check1("t1_busy_cleared", io.busy, 1'b0);
    check1("t1_ready_lag",    io.bus_ready, 1'b0);
    tick();
    check1("t1_ready_back",   io.bus_ready, 1'b1);

    // full set, then back-pressure with 0x55 held through WAIT
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h01); send_byte(8'h23);
    tick(); tick();
    check1 ("t2_start", io.start, 1'b1);
    check16("t2_dvd", io.dividend_16b, 16'hABCD);
    check16("t2_dvs", io.divisor_16b,  16'h0123);
    io.bus_in = 8'h55; io.bus_valid = 1'b1;
    repeat (4) begin
      tick();
      check1 ("t3_ready_low", io.bus_ready, 1'b0);
      check1 ("t3_busy",      io.busy,      1'b1);
      check16("t3_dvd_held",  io.dividend_16b, 16'hABCD);
    end
    pulse_done();
    tick();
    check16("t3_no_capture_yet", io.dividend_16b, 16'hABCD);
    tick();
    io.bus_valid = 1'b0;
    check16("t3_slot0", io.dividend_16b, 16'h55CD);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    tick(); tick();
    check1 ("t3_start", io.start, 1'b1);
    check16("t3_dvd", io.dividend_16b, 16'h5501);
    check16("t3_dvs", io.divisor_16b,  16'h0003);
    tick();
    pulse_done();
    tick();

    // zero divisor
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    tick();
    check1("t4_dz_n1",    io.dz_err,    1'b0);
    check1("t4_ready_n1", io.bus_ready, 1'b0);
    tick();
    check1("t4_dz",       io.dz_err,    1'b1);
    check1("t4_ready",    io.bus_ready, 1'b1);
    check1("t4_nostart",  io.start,     1'b0);
    tick();
    check1("t4_dz_once",  io.dz_err,    1'b0);
    check16("t4_dvd",     io.dividend_16b, 16'h0010);

    // div_ready held low in ISSUE, spurious done in COLLECT
    io.div_ready = 1'b0;
    send_byte(8'h12);
    pulse_done();
    check1("t5_spurious_busy",  io.busy,      1'b0);
    check1("t5_spurious_ready", io.bus_ready, 1'b1);
    send_byte(8'h34); send_byte(8'h00); send_byte(8'h05);
    repeat (5) begin
      tick();
      check1 ("t5_no_start", io.start, 1'b0);
      check16("t5_dvd", io.dividend_16b, 16'h1234);
      check16("t5_dvs", io.divisor_16b,  16'h0005);
    end
    io.div_ready = 1'b1;
    tick();
    check1("t5_start", io.start, 1'b1);
    io.div_ready = 1'b0;
    tick();
    pulse_done();
    tick();

    // randomized operand sets
    rnd_on = 1'b1;
    for (int unsigned s = 0; s < 150; s++) begin
      for (int unsigned k = 0; k < 4; k++) sb[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sb[2] = 8'h00; sb[3] = 8'h00;
      end else if ($urandom_range(0, 3) == 0) begin
        sb[0] = 8'h00;
      end
      for (int unsigned k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (k == 2 && $urandom_range(0, 19) == 0) do_reset();
        send_byte(sb[k]);
      end
    end
    rnd_on = 1'b0;
    io.div_done = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
